// File: rtl/popcount11_pkg.sv
// Shared constants, state type and thermometer helper for the popcount11 unary
// transmitter family.
//   N_BITS : unary word length / serial beats per count
//   CW     : count width, ceil(log2(N_BITS+1))
//   therm(): clamp a count to N_BITS and expand it to a thermometer word
package popcount11_pkg;

  localparam int N_BITS = 11;
  localparam int CW     = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // Bit i is set when i < count; counts above N_BITS saturate to all ones
  // because the loop only spans N_BITS positions.
  function automatic logic [N_BITS-1:0] therm(input logic [CW-1:0] count);
    logic [N_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < N_BITS; i++) begin
      w[i] = (CW'(i) < count);
    end
    return w;
  endfunction

endpackage

// File: rtl/popcount11_unary_tx_if.sv
// Handshake bundle between a count producer / serial sink and popcount11_unary_tx.
//   in_valid/in_ready/in_count      : count input handshake
//   ser_valid/ser_ready/ser_bit/ser_last : serial unary stream
//   par_word                        : thermometer word of the last accepted count
//   sat_err                         : only when POPCOUNT11_SAT_FLAG_EN is defined
// Modports: master = producer/sink side, slave = transmitter side.
interface popcount11_unary_tx_if;
  import popcount11_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_count;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_bit;
  logic              ser_last;
  logic [N_BITS-1:0] par_word;
`ifdef POPCOUNT11_SAT_FLAG_EN
  logic              sat_err;
`endif

  modport master (
    output in_valid, in_count, ser_ready,
    input  in_ready, ser_valid, ser_bit, ser_last, par_word
`ifdef POPCOUNT11_SAT_FLAG_EN
    , input sat_err
`endif
  );

  modport slave (
    input  in_valid, in_count, ser_ready,
    output in_ready, ser_valid, ser_bit, ser_last, par_word
`ifdef POPCOUNT11_SAT_FLAG_EN
    , output sat_err
`endif
  );

endinterface

// File: rtl/popcount11_therm_enc.sv
// Combinational clamp + thermometer expansion of a count.
//   count : CW-bit count, 0..15 legal on the wire
//   word  : N_BITS thermometer word with min(count, N_BITS) low bits set
module popcount11_therm_enc
  import popcount11_pkg::*;
(
  input  logic [CW-1:0]     count,
  output logic [N_BITS-1:0] word
);

  assign word = therm(count);

endmodule

// File: rtl/popcount11_unary_tx.sv
// Expands an accepted 4-bit count into an 11-bit thermometer word and streams it
// one bit per valid/ready beat.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : popcount11_unary_tx_if.slave (count input, serial output, par_word)
// Optional: POPCOUNT11_SAT_FLAG_EN adds a registered sat_err flag (count > N_BITS).
// LSB_FIRST selects whether word bit 0 or bit N_BITS-1 leaves first.
module popcount11_unary_tx
  import popcount11_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  popcount11_unary_tx_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state_r;
  logic [N_BITS-1:0] shreg_r;
  logic [N_BITS-1:0] par_word_r;
  logic [CW-1:0]     beat_cnt_r;
  logic [N_BITS-1:0] enc_word_s;
  logic              ser_last_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              beat_s;

  popcount11_therm_enc u_enc (
    .count (bus.in_count),
    .word  (enc_word_s)
  );

  // The counter is cleared on return to IDLE, so ser_last can only be high in SHIFT.
  assign ser_last_s = (beat_cnt_r == CW'(N_BITS - 1));
  assign beat_s     = (state_r == ST_SHIFT) & bus.ser_ready;
  // Taking the last beat frees the register in the same cycle: no bubble between words.
  assign in_ready_s = (state_r == ST_IDLE) | (ser_last_s & bus.ser_ready);
  assign accept_s   = bus.in_valid & in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.ser_valid = (state_r == ST_SHIFT);
  assign bus.ser_last  = ser_last_s;
  assign bus.ser_bit   = LSB_FIRST ? shreg_r[0] : shreg_r[N_BITS-1];
  assign bus.par_word  = par_word_r;

  // Word load on accept, shift and count on each beat, return to IDLE after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      par_word_r <= '0;
      beat_cnt_r <= '0;
    end else if (accept_s) begin
      state_r    <= ST_SHIFT;
      shreg_r    <= enc_word_s;
      par_word_r <= enc_word_s;
      beat_cnt_r <= '0;
    end else if (beat_s) begin
      if (ser_last_s) begin
        // Clearing the shifter keeps ser_bit low while idle.
        state_r    <= ST_IDLE;
        shreg_r    <= '0;
        beat_cnt_r <= '0;
      end else begin
        shreg_r    <= LSB_FIRST ? (shreg_r >> 1) : (shreg_r << 1);
        beat_cnt_r <= beat_cnt_r + CW'(1);
      end
    end
  end

`ifdef POPCOUNT11_SAT_FLAG_EN
  logic sat_err_r;

  // Saturation flag captured with each accepted count and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_err_r <= 1'b0;
    end else if (accept_s) begin
      sat_err_r <= (bus.in_count > CW'(N_BITS));
    end
  end

  assign bus.sat_err = sat_err_r;
`endif

endmodule
